pipeline_sequencer: RTL and testbench
=====================================

Name: pipeline_sequencer

Overview:
- Central run/step/halt and hazard controller for the 5-stage MIPS pipeline.
- Drives the PC enable, the IF/ID enable and flush, the ID/EX bubble (i_stall) and the global stage-register freeze (i_halt) of the decode stage and its neighbours.
- Supports continuous run and single-step for the debug unit.
- On a decoded HALT, drains the remaining stages, then reports done together with cycle and stall counters.

Parameters:
NB_ADDR, 5, register address width
NB_CNT, 32, width of cycle and stall counters
N_DRAIN, 4, cycles needed to retire everything behind ID after HALT (EX, MEM, WB, RF write)

Ports:
clk  in  1  single system clock, rising edge
i_rst  in  1  asynchronous, active-high reset
i_mode_cont  in  1  1 = continuous run, 0 = single-step; sampled only in IDLE
i_start  in  1  one-cycle pulse, begin execution
i_step  in  1  one-cycle pulse, advance pipeline one cycle (step mode)
i_stop_id  in  1  HALT instruction flag from decode stage (o_stop)
i_jump_id  in  1  jump/taken-branch resolved in ID
i_id_rs  in  NB_ADDR  rs of instruction in ID
i_id_rt  in  NB_ADDR  rt of instruction in ID
i_ex_rt  in  NB_ADDR  rt of instruction in EX
i_ex_memRead  in  1  EX instruction is a load
o_pc_en  out  1  PC update enable
o_if_id_en  out  1  IF/ID register enable
o_if_id_flush  out  1  zero IF/ID instruction (NOP)
o_id_stall  out  1  insert bubble in ID/EX (control bits zeroed)
o_pipe_halt  out  1  freeze all stage registers
o_done  out  1  program finished, pipeline drained
o_state  out  3  current FSM state
o_cycle_cnt  out  NB_CNT  advancing cycles executed
o_stall_cnt  out  NB_CNT  load-use stalls inserted

Behaviour:
- The state register is the only clocked control state. All control outputs are combinational from state and inputs (zero latency).
- State encodings: IDLE=0, RUN=1, PAUSE=2, STEP=3, DRAIN=4, DONE=5.
- Reset (async, any time, including mid-DRAIN):
  - state=IDLE, drain counter=0, both counters=0.
  - Outputs: o_pipe_halt=1, o_pc_en=0, o_if_id_en=0, o_if_id_flush=0, o_id_stall=0, o_done=0.
- "adv" = state ∈ {RUN, STEP, DRAIN}. Whenever !adv, o_pipe_halt=1 and all other enables are 0.
- IDLE:
  - i_start & i_mode_cont → RUN.
  - i_step, or i_start & !i_mode_cont → STEP.
  - i_start & i_step together: mode decides.
- RUN: stays until i_stop_id=1 → DRAIN.
- STEP: exactly one advancing cycle, then → PAUSE; i_stop_id=1 → DRAIN instead.
- PAUSE: i_step → STEP. i_start is ignored.
- DRAIN:
  - On entry, the counter loads N_DRAIN-1 and decrements each cycle.
  - At 0 → DONE, so DRAIN lasts exactly N_DRAIN cycles regardless of step mode.
- DONE: o_done=1, o_pipe_halt=1. Sticky until i_rst; i_start and i_step are ignored.
- In RUN/STEP (normal advance): o_pipe_halt=0, o_pc_en=1, o_if_id_en=1.
- Load-use hazard:
  - Condition: adv & state≠DRAIN & i_ex_memRead & i_ex_rt≠0 & (i_ex_rt==i_id_rs | i_ex_rt==i_id_rt).
  - Response: o_pc_en=0, o_if_id_en=0, o_id_stall=1; o_stall_cnt increments.
  - A stalled STEP cycle still counts as the step.
- Jump:
  - i_jump_id & no load-use hazard → o_if_id_flush=1, PC still enabled.
  - Load-use has priority: no flush while stalled, because the branch operands are stale.
- HALT cycle and all DRAIN cycles: o_pc_en=0, o_if_id_en=1, o_if_id_flush=1, o_id_stall=1 (the trailing fetch is killed), o_pipe_halt=0.
- o_cycle_cnt increments on every adv cycle and saturates at all-ones; o_stall_cnt also saturates.
- i_stop_id or i_jump_id while !adv is ignored.

Decomposition:
- Shared package pipe_ctrl_pkg holds: state localparams (IDLE…DONE), default N_DRAIN, and a REG_ZERO=5'd0 constant.
- Sub-module hazard_detect (combinational) computes the load-use condition from the rs/rt/memRead ports. The FSM and counters live in pipeline_sequencer.

Test Plan:
- Reset mid-DRAIN (state=4) → next cycle state=0, o_pipe_halt=1, both counters=0, o_done=0.
- mode_cont=1, start pulse, HALT raised on the 10th RUN cycle → 4 DRAIN cycles with o_pc_en=0 and flush=1, then o_done=1, o_cycle_cnt=14.
- RUN with i_ex_memRead=1, i_ex_rt=5, i_id_rs=5 → o_pc_en=0, o_if_id_en=0, o_id_stall=1, o_stall_cnt+1. With i_ex_rt=0 → no stall.
- Load-use and i_jump_id in the same cycle → stall asserted, o_if_id_flush=0. Next cycle (hazard gone) jump → flush=1, pc_en=1.
- mode_cont=0, three i_step pulses spaced 5 cycles apart → exactly 3 cycles with o_pipe_halt=0, state PAUSE between them, o_cycle_cnt=3.
- DONE state with i_start and i_step pulsed → remains DONE, counters frozen, o_done=1.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared control definitions for the pipeline sequencer.
// FSM state encoding, drain depth default and the zero register id.
package pipe_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        PAUSE = 3'd2,
        STEP  = 3'd3,
        DRAIN = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int N_DRAIN_DEF = 4;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detector: a load in EX writing a register read in ID.
// Loads targeting the zero register never create a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_ADDR = 5
) (
    input  logic [NB_ADDR-1:0] id_rs_i,
    input  logic [NB_ADDR-1:0] id_rt_i,
    input  logic [NB_ADDR-1:0] ex_rt_i,
    input  logic               ex_mem_read_i,
    output logic               load_use_o
);

    logic rt_nonzero;
    logic rt_match;

    assign rt_nonzero = (ex_rt_i != NB_ADDR'(REG_ZERO));
    assign rt_match   = (ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i);
    assign load_use_o = ex_mem_read_i && rt_nonzero && rt_match;

endmodule

// File: rtl/pipeline_sequencer.sv
// Run/step/halt and hazard controller for the 5-stage pipeline.
// Only the FSM, drain counter and statistics counters are clocked.
module pipeline_sequencer
    import pipe_ctrl_pkg::*;
#(
    parameter int NB_ADDR = 5,
    parameter int NB_CNT  = 32,
    parameter int N_DRAIN = N_DRAIN_DEF
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic               i_mode_cont,
    input  logic               i_start,
    input  logic               i_step,
    input  logic               i_stop_id,
    input  logic               i_jump_id,
    input  logic [NB_ADDR-1:0] i_id_rs,
    input  logic [NB_ADDR-1:0] i_id_rt,
    input  logic [NB_ADDR-1:0] i_ex_rt,
    input  logic               i_ex_memRead,
    output logic               o_pc_en,
    output logic               o_if_id_en,
    output logic               o_if_id_flush,
    output logic               o_id_stall,
    output logic               o_pipe_halt,
    output logic               o_done,
    output logic [2:0]         o_state,
    output logic [NB_CNT-1:0]  o_cycle_cnt,
    output logic [NB_CNT-1:0]  o_stall_cnt
);

    localparam int NB_DRN = (N_DRAIN > 1) ? $clog2(N_DRAIN) : 1;

    state_t              state_q, state_d;
    logic [NB_DRN-1:0]   drn_q, drn_d;
    logic [NB_CNT-1:0]   cyc_q, cyc_d;
    logic [NB_CNT-1:0]   stl_q, stl_d;
    logic                haz;
    logic                adv;
    logic                load_use;

    hazard_detect #(
        .NB_ADDR (NB_ADDR)
    ) u_hazard (
        .id_rs_i       (i_id_rs),
        .id_rt_i       (i_id_rt),
        .ex_rt_i       (i_ex_rt),
        .ex_mem_read_i (i_ex_memRead),
        .load_use_o    (haz)
    );

    assign adv      = (state_q == RUN) || (state_q == STEP) ||
                      (state_q == DRAIN);
    assign load_use = adv && (state_q != DRAIN) && haz;

    always_comb begin
        state_d       = state_q;
        drn_d         = drn_q;
        o_pc_en       = 1'b0;
        o_if_id_en    = 1'b0;
        o_if_id_flush = 1'b0;
        o_id_stall    = 1'b0;
        o_pipe_halt   = 1'b1;
        o_done        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (i_start)
                    state_d = i_mode_cont ? RUN : STEP;
                else if (i_step)
                    state_d = STEP;
            end
            RUN, STEP: begin
                o_pipe_halt = 1'b0;
                if (i_stop_id) begin
                    // HALT in ID: keep stages moving, kill the trailing fetch
                    o_if_id_en    = 1'b1;
                    o_if_id_flush = 1'b1;
                    o_id_stall    = 1'b1;
                    state_d       = DRAIN;
                    drn_d         = NB_DRN'(N_DRAIN - 1);
                end else begin
                    if (load_use) begin
                        o_id_stall = 1'b1;
                    end else begin
                        o_pc_en       = 1'b1;
                        o_if_id_en    = 1'b1;
                        o_if_id_flush = i_jump_id;
                    end
                    if (state_q == STEP)
                        state_d = PAUSE;
                end
            end
            PAUSE: begin
                if (i_step)
                    state_d = STEP;
            end
            DRAIN: begin
                o_pipe_halt   = 1'b0;
                o_if_id_en    = 1'b1;
                o_if_id_flush = 1'b1;
                o_id_stall    = 1'b1;
                if (drn_q == '0)
                    state_d = DONE;
                else
                    drn_d = drn_q - NB_DRN'(1);
            end
            DONE: begin
                o_done = 1'b1;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        cyc_d = cyc_q;
        stl_d = stl_q;
        if (adv && !(&cyc_q))
            cyc_d = cyc_q + NB_CNT'(1);
        if (load_use && !(&stl_q))
            stl_d = stl_q + NB_CNT'(1);
    end

    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            drn_q   <= '0;
            cyc_q   <= '0;
            stl_q   <= '0;
        end else begin
            state_q <= state_d;
            drn_q   <= drn_d;
            cyc_q   <= cyc_d;
            stl_q   <= stl_d;
        end
    end

    assign o_state     = state_q;
    assign o_cycle_cnt = cyc_q;
    assign o_stall_cnt = stl_q;

endmodule

// File: tb/tb_pipeline_sequencer.sv
// Scoreboard bench for pipeline_sequencer control outputs and counters.
// Expected control vectors are queued as stimulus is applied.
module tb_pipeline_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        mode;
    logic        start;
    logic        step;
    logic        stop;
    logic        jump;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  exrt;
    logic        memrd;
    logic        pc_en;
    logic        ifid_en;
    logic        flush;
    logic        stall;
    logic        halt;
    logic        done;
    logic [2:0]  state;
    logic [31:0] cyc_cnt;
    logic [31:0] stl_cnt;

    int n_tot = 0;
    int n_bad = 0;
    int adv_seen = 0;

    // {state, halt, pc_en, if_id_en, flush, stall, done}
    typedef logic [8:0] ev_t;
    localparam ev_t E_IDLE  = 9'b000_1_0_0_0_0_0;
    localparam ev_t E_RUN   = 9'b001_0_1_1_0_0_0;
    localparam ev_t E_LU    = 9'b001_0_0_0_0_1_0;
    localparam ev_t E_JMP   = 9'b001_0_1_1_1_0_0;
    localparam ev_t E_HLT   = 9'b001_0_0_1_1_1_0;
    localparam ev_t E_PAUSE = 9'b010_1_0_0_0_0_0;
    localparam ev_t E_STEP  = 9'b011_0_1_1_0_0_0;
    localparam ev_t E_DRN   = 9'b100_0_0_1_1_1_0;
    localparam ev_t E_DONE  = 9'b101_1_0_0_0_0_1;

    ev_t sbq[$];

    always #5 clk = ~clk;

    pipeline_sequencer dut (
        .clk           (clk),
        .i_rst         (rst),
        .i_mode_cont   (mode),
        .i_start       (start),
        .i_step        (step),
        .i_stop_id     (stop),
        .i_jump_id     (jump),
        .i_id_rs       (rs),
        .i_id_rt       (rt),
        .i_ex_rt       (exrt),
        .i_ex_memRead  (memrd),
        .o_pc_en       (pc_en),
        .o_if_id_en    (ifid_en),
        .o_if_id_flush (flush),
        .o_id_stall    (stall),
        .o_pipe_halt   (halt),
        .o_done        (done),
        .o_state       (state),
        .o_cycle_cnt   (cyc_cnt),
        .o_stall_cnt   (stl_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Called at a negedge with inputs already set; returns at next negedge.
    task automatic cyc(input string tag, input ev_t e);
        ev_t want;
        sbq.push_back(e);
        #2;
        want = sbq.pop_front();
        chk(tag, {23'd0, state, halt, pc_en, ifid_en, flush, stall, done},
            {23'd0, want});
        if (!halt)
            adv_seen++;
        @(negedge clk);
    endtask

    task automatic clr_in();
        start = 0; step = 0; stop = 0; jump = 0;
        rs = 0; rt = 0; exrt = 0; memrd = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_state", {29'd0, state}, 32'd0);
        chk("rst_halt", {31'd0, halt}, 32'd1);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_cyc", cyc_cnt, 32'd0);
        chk("rst_stl", stl_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        clr_in();
        mode = 1'b1;
        rst  = 1'b0;
        @(negedge clk);
        do_reset();
        chk("idle_out", {23'd0, state, halt, pc_en, ifid_en, flush,
                         stall, done}, {23'd0, E_IDLE});

        // Continuous run, HALT on the 10th RUN cycle
        mode = 1'b1;
        start = 1; cyc("run_start", E_IDLE); start = 0;
        for (int i = 0; i < 9; i++)
            cyc("run", E_RUN);
        stop = 1; cyc("halt", E_HLT); stop = 0;
        repeat (4) cyc("drain", E_DRN);
        cyc("done", E_DONE);
        chk("run_cyc", cyc_cnt, 32'd14);
        chk("run_stl", stl_cnt, 32'd0);

        // DONE is sticky against start/step
        start = 1; step = 1; cyc("done_hold", E_DONE);
        start = 0; step = 0; cyc("done_hold2", E_DONE);
        chk("done_cyc", cyc_cnt, 32'd14);

        // Reset in the middle of DRAIN
        do_reset();
        start = 1; cyc("md_start", E_IDLE); start = 0;
        cyc("md_run", E_RUN);
        stop = 1; cyc("md_halt", E_HLT); stop = 0;
        cyc("md_drain", E_DRN);
        chk("md_in_drain", {29'd0, state}, 32'd4);
        do_reset();

        // Load-use hazards and jump priority
        start = 1; cyc("lu_start", E_IDLE); start = 0;
        memrd = 1; exrt = 5; rs = 5; cyc("lu_rs", E_LU);
        chk("lu_cnt1", stl_cnt, 32'd1);
        exrt = 0; rs = 0; cyc("lu_zero", E_RUN);
        chk("lu_cnt1b", stl_cnt, 32'd1);
        exrt = 7; rs = 3; rt = 7; jump = 1; cyc("lu_jump", E_LU);
        memrd = 0; cyc("jump", E_JMP);
        jump = 0;
        chk("lu_cnt2", stl_cnt, 32'd2);
        memrd = 1; exrt = 6; rs = 5; rt = 4; cyc("lu_nomatch", E_RUN);
        clr_in();
        chk("lu_cyc", cyc_cnt, 32'd5);
        do_reset();

        // Single-step mode
        mode = 1'b0;
        adv_seen = 0;
        step = 1; cyc("st_idle", E_IDLE); step = 0;
        cyc("step1", E_STEP);
        repeat (4) cyc("pause1", E_PAUSE);
        step = 1; cyc("st_p1", E_PAUSE); step = 0;
        cyc("step2", E_STEP);
        repeat (3) cyc("pause2", E_PAUSE);
        start = 1; cyc("st_ign", E_PAUSE); start = 0;
        step = 1; cyc("st_p2", E_PAUSE); step = 0;
        cyc("step3", E_STEP);
        cyc("pause3", E_PAUSE);
        chk("st_adv", adv_seen, 32'd3);
        chk("st_cyc", cyc_cnt, 32'd3);

        if (sbq.size() != 0)
            chk("sb_empty", sbq.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
